divider_seq: RTL and testbench

- Multi-cycle, parametrised integer divider for the M-extension datapath.
- Supports signed and unsigned divide and remainder: DIV, DIVU, REM, REMU.
- Uses restoring division and retires STEPS quotient bits per clock.
- Sits beside the ALU; the control unit stalls the pipeline while busy is high and consumes the result on valid.

---
 rtl/divider_seq.sv | 147 ++++++++++++++
 tb/tb_divider_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU), STEPS quotient bits per clock.
// Optional DIVIDER_SEQ_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on the accepting edge
// RUN    | STEPS restoring steps per clock, counter counts N/STEPS down to 1
// DONE   | valid_o high for this one cycle, then back to IDLE
module divider_seq #(
    parameter int N     = 32,
    parameter int STEPS = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic         busy_o,
    output logic         valid_o,
    output logic [N-1:0] result_o
);

    localparam int ITER = N / STEPS;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [N:0]    rem_q;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  dvs_q;
    logic [N-1:0]  result_q;
    logic          valid_q;
    logic          rem_sel_q;
    logic          neg_quo_q;
    logic          neg_rem_q;
    logic          div0_q;
    logic          ovf_q;

    logic          signed_in;
    logic          dvd_neg;
    logic          dvs_neg;
    logic [N-1:0]  dvd_mag;
    logic [N-1:0]  dvs_mag;
    logic          div0_in;
    logic          ovf_in;

    logic [N:0]    rem_nx;
    logic [N-1:0]  quo_nx;
    logic [N:0]    diff;
    logic [N-1:0]  quo_fix;
    logic [N-1:0]  rem_fix;
    logic [N-1:0]  final_res;

    assign signed_in = ~op_i[0];
    assign dvd_neg   = signed_in & dividend_i[N-1];
    assign dvs_neg   = signed_in & divisor_i[N-1];
    assign dvd_mag   = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign dvs_mag   = dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
    assign div0_in   = (divisor_i == '0);
    assign ovf_in    = signed_in & (dividend_i == MIN_NEG) & (divisor_i == '1);

    // rem stays below the divisor between steps, so the shifted value fits in N+1 bits
    always_comb begin
        rem_nx = rem_q;
        quo_nx = quo_q;
        diff   = '0;
        for (int i = 0; i < STEPS; i++) begin
            rem_nx = {rem_nx[N-1:0], quo_nx[N-1]};
            quo_nx = {quo_nx[N-2:0], 1'b0};
            diff   = rem_nx - {1'b0, dvs_q};
            if (!diff[N]) begin
                rem_nx    = diff;
                quo_nx[0] = 1'b1;
            end
        end
    end

    // divide-by-zero remainder falls out of the iteration: |dividend| re-signed is the dividend
    assign quo_fix   = div0_q ? '1 : (ovf_q ? MIN_NEG :
                       (neg_quo_q ? (~quo_nx + 1'b1) : quo_nx));
    assign rem_fix   = ovf_q ? '0 :
                       (neg_rem_q ? (~rem_nx[N-1:0] + 1'b1) : rem_nx[N-1:0]);
    assign final_res = rem_sel_q ? rem_fix : quo_fix;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rem_sel_q <= op_i[1];
                        neg_quo_q <= dvd_neg ^ dvs_neg;
                        neg_rem_q <= dvd_neg;
                        div0_q    <= div0_in;
                        ovf_q     <= ovf_in;
                        rem_q     <= '0;
                        quo_q     <= dvd_mag;
                        dvs_q     <= dvs_mag;
                        cnt_q     <= CW'(ITER);
                        state_q   <= S_RUN;
`ifdef DIVIDER_SEQ_EARLY_OUT_EN
                        if (div0_in || ovf_in) begin
                            result_q <= op_i[1] ? (div0_in ? dividend_i : '0)
                                                : (div0_in ? '1 : MIN_NEG);
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end
`endif
                    end
                end
                S_RUN: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        result_q <= final_res;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq: one instance per STEPS value (1, 2, 4, 8), N=32.
module tb_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [3:0]  busy;
    logic [3:0]  valid;
    logic [31:0] res [4];

    int n_checks = 0;
    int n_errors = 0;

`ifdef DIVIDER_SEQ_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        divider_seq #(.N(32), .STEPS(1 << g)) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .start_i    (start[g]),
            .op_i       (op),
            .dividend_i (dividend),
            .divisor_i  (divisor),
            .busy_o     (busy[g]),
            .valid_o    (valid[g]),
            .result_o   (res[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        if (o[0]) return o[1] ? (a % b) : (a / b);
        return o[1] ? $unsigned($signed(a) % $signed(b)) : $unsigned($signed(a) / $signed(b));
    endfunction

    // start in cycle 0, then count cycles until valid; busy must be high in every one of them
    task automatic do_op(input int k, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r,
                         input int exp_lat, input string tag);
        int lat;
        int bcnt;
        @(negedge clk);
        op       = o;
        dividend = a;
        divisor  = b;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!valid[k] && lat < 100) begin
            if (busy[k]) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (busy[k]) bcnt++;
        check({tag, "_res"}, res[k], exp_r);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(bcnt), 32'(exp_lat));
        @(negedge clk);
        check({tag, "_vpulse"}, 32'(valid[k]), 32'd0);
    endtask

    initial begin
        int lat_sp;
        int vcyc;
        int cyc;
        int vcount;
        logic [31:0] vres;
        logic b34;
        logic b35;

        lat_sp   = EARLY ? 1 : 33;
        rst      = 1'b1;
        start    = '0;
        op       = '0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_res",   res[0], 32'd0);
        rst = 1'b0;

        do_op(0, 2'b01, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
        do_op(0, 2'b11, 32'd100, 32'd7, 32'd2,  33, "remu_100_7");

        do_op(0, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
        do_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
        do_op(0, 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
        do_op(0, 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1,         33, "rem_7_m2");
        do_op(0, 2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, "divu_big_2");

        do_op(0, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, lat_sp, "div_5_0");
        do_op(0, 2'b11, 32'd5, 32'd0, 32'd5,         lat_sp, "remu_5_0");
        do_op(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, lat_sp, "div_ovf");
        do_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         lat_sp, "rem_ovf");

        // start held high across a whole operation with operands changing every cycle
        @(negedge clk);
        op       = 2'b01;
        dividend = 32'd100;
        divisor  = 32'd7;
        start[0] = 1'b1;
        vcyc = 0;
        vres = '0;
        b34  = 1'b1;
        b35  = 1'b0;
        for (int c = 1; c <= 39; c++) begin
            @(negedge clk);
            if (valid[0] && vcyc == 0) begin
                vcyc = c;
                vres = res[0];
            end
            if (c == 34) b34 = busy[0];
            if (c == 35) b35 = busy[0];
            dividend = 32'(1000 + c);
        end
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 40;
        while (!valid[0] && cyc < 120) begin
            @(negedge clk);
            cyc++;
        end
        check("hs_first_cyc",  32'(vcyc), 32'd33);
        check("hs_first_res",  vres, 32'd14);
        check("hs_done_start_dropped", 32'(b34), 32'd0);
        check("hs_second_accept", 32'(b35), 32'd1);
        check("hs_second_cyc", 32'(cyc), 32'd67);
        check("hs_second_res", res[0], 32'd147);
        @(negedge clk);

        // reset in cycle 10 of a running DIVU
        @(negedge clk);
        op       = 2'b01;
        dividend = 32'd1000;
        divisor  = 32'd3;
        start[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (c == 10) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",  32'(busy[0]), 32'd0);
        check("midrst_valid", 32'(valid[0]), 32'd0);
        check("midrst_res",   res[0], 32'd0);
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid[0]) vcount++;
        end
        check("midrst_no_valid", 32'(vcount), 32'd0);
        do_op(0, 2'b01, 32'd9, 32'd3, 32'd3, 33, "post_rst");

        do_op(2, 2'b01, 32'hDEAD_BEEF, 32'h0000_1234, 32'h000C_3BA5, 9, "s4_divu");
        do_op(2, 2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 32'h0000_076B, 9, "s4_remu");

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 25; i++) begin
                logic [1:0]  o;
                logic [31:0] a;
                logic [31:0] b;
                bit          sp;
                o = 2'($urandom_range(0, 3));
                a = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
                case (i % 5)
                    0:       b = $urandom;
                    1:       b = $urandom_range(1, 255);
                    2:       b = 32'd0;
                    3:       b = 32'hFFFF_FFFF;
                    default: b = $urandom >> $urandom_range(0, 31);
                endcase
                sp = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
                do_op(k, o, a, b, ref_div(o, a, b),
                      (sp && EARLY) ? 1 : (32 >> k) + 1, $sformatf("rnd_s%0d_%0d", 1 << k, i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
